// File: rtl/uart_rx_core.sv
// 8N1 UART receiver: two-flop input synchronizer, mid-bit sampling FSM and a
// one-byte holding register with overrun and framing-error reporting.
module uart_rx_core #(
    parameter int CLKS_PER_BIT = 87
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx,
    input  logic       data_ack,
    output logic [7:0] rx_data,
    output logic       data_valid,
    output logic       frame_err,
    output logic       overrun,
    output logic       busy
);

    localparam int SYNC_STAGES = 2;
    localparam int TW = $clog2(CLKS_PER_BIT);
    localparam logic [TW-1:0] HALF_LAST = TW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [TW-1:0] BIT_LAST  = TW'(CLKS_PER_BIT - 1);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        STOP,
        WAIT_HIGH
    } state_t;

    logic [SYNC_STAGES-1:0] sync_reg, sync_next;
    logic                   rx_s;

    state_t        state_reg, state_next;
    logic [TW-1:0] timer_reg, timer_next;
    logic [2:0]    index_reg, index_next;
    logic [7:0]    shift_reg, shift_next;
    logic [7:0]    rx_data_reg, rx_data_next;
    logic          data_valid_reg, data_valid_next;
    logic          frame_err_reg, frame_err_next;
    logic          overrun_reg, overrun_next;
    logic          commit;
    logic          ack_hit;

    // Synchronizer chain idles high so reset never looks like a start bit.
    generate
        for (genvar gi = 0; gi < SYNC_STAGES; gi++) begin : g_sync
            if (gi == 0) begin : g_first
                assign sync_next[gi] = rx;
            end else begin : g_rest
                assign sync_next[gi] = sync_reg[gi-1];
            end
        end
    endgenerate

    assign rx_s = sync_reg[SYNC_STAGES-1];

    always_comb begin
        state_next     = state_reg;
        timer_next     = timer_reg + TW'(1);
        index_next     = index_reg;
        shift_next     = shift_reg;
        commit         = 1'b0;
        frame_err_next = 1'b0;
        case (state_reg)
            IDLE: begin
                timer_next = '0;
                if (!rx_s) begin
                    state_next = START;
                end
            end
            START: begin
                if (timer_reg == HALF_LAST) begin
                    timer_next = '0;
                    index_next = '0;
                    state_next = rx_s ? IDLE : DATA;
                end
            end
            DATA: begin
                if (timer_reg == BIT_LAST) begin
                    timer_next = '0;
                    shift_next = {rx_s, shift_reg[7:1]};
                    index_next = index_reg + 3'd1;
                    if (index_reg == 3'd7) begin
                        state_next = STOP;
                    end
                end
            end
            STOP: begin
                if (timer_reg == BIT_LAST) begin
                    timer_next = '0;
                    if (rx_s) begin
                        commit     = 1'b1;
                        state_next = IDLE;
                    end else begin
                        frame_err_next = 1'b1;
                        state_next     = WAIT_HIGH;
                    end
                end
            end
            WAIT_HIGH: begin
                timer_next = '0;
                if (rx_s) begin
                    state_next = IDLE;
                end
            end
            default: begin
                timer_next = '0;
                state_next = IDLE;
            end
        endcase
    end

    // A coincident ack frees the holding register, so the new byte is taken.
    assign ack_hit = data_ack && data_valid_reg;

    always_comb begin
        rx_data_next    = rx_data_reg;
        data_valid_next = data_valid_reg;
        overrun_next    = overrun_reg;
        if (ack_hit) begin
            data_valid_next = 1'b0;
            overrun_next    = 1'b0;
        end
        if (commit) begin
            if (data_valid_reg && !data_ack) begin
                overrun_next = 1'b1;
            end else begin
                rx_data_next    = shift_reg;
                data_valid_next = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sync_reg       <= '1;
            state_reg      <= IDLE;
            timer_reg      <= '0;
            index_reg      <= '0;
            shift_reg      <= '0;
            rx_data_reg    <= '0;
            data_valid_reg <= 1'b0;
            frame_err_reg  <= 1'b0;
            overrun_reg    <= 1'b0;
        end else begin
            sync_reg       <= sync_next;
            state_reg      <= state_next;
            timer_reg      <= timer_next;
            index_reg      <= index_next;
            shift_reg      <= shift_next;
            rx_data_reg    <= rx_data_next;
            data_valid_reg <= data_valid_next;
            frame_err_reg  <= frame_err_next;
            overrun_reg    <= overrun_next;
        end
    end

    assign rx_data    = rx_data_reg;
    assign data_valid = data_valid_reg;
    assign frame_err  = frame_err_reg;
    assign overrun    = overrun_reg;
    assign busy       = (state_reg != IDLE);

endmodule

// File: tb/tb_uart_rx_core.sv
// Self-checking bench for uart_rx_core at 8 clocks per bit: directed frames,
// then random frames checked against a byte-level holding-register model.
module tb_uart_rx_core;

    localparam int CPB   = 8;
    localparam int FRAME = 10 * CPB;
    // Edge index (from first edge seeing the start bit) at which data_valid
    // rises: 2 sync stages, half a bit to confirm start, 9 bits to stop mid.
    localparam int DV_CYCLE = 2 + CPB / 2 + 9 * CPB;

    logic       clk = 1'b0;
    logic       rst;
    logic       rx;
    logic       data_ack;
    logic [7:0] rx_data;
    logic       data_valid;
    logic       frame_err;
    logic       overrun;
    logic       busy;

    int checks   = 0;
    int failures = 0;

    logic [7:0] m_data;
    logic       m_valid;
    logic       m_overrun;

    uart_rx_core #(.CLKS_PER_BIT(CPB)) dut (
        .clk        (clk),
        .rst        (rst),
        .rx         (rx),
        .data_ack   (data_ack),
        .rx_data    (rx_data),
        .data_valid (data_valid),
        .frame_err  (frame_err),
        .overrun    (overrun),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_model(input string tag);
        chk({tag, "_data"}, 32'(rx_data), 32'(m_data));
        chk({tag, "_valid"}, 32'(data_valid), 32'(m_valid));
        chk({tag, "_overrun"}, 32'(overrun), 32'(m_overrun));
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, "_data"}, 32'(rx_data), 32'h00);
        chk({tag, "_valid"}, 32'(data_valid), 32'h0);
        chk({tag, "_ferr"}, 32'(frame_err), 32'h0);
        chk({tag, "_overrun"}, 32'(overrun), 32'h0);
        chk({tag, "_busy"}, 32'(busy), 32'h0);
    endtask

    task automatic idle(input int n);
        rx = 1'b1;
        data_ack = 1'b0;
        repeat (n) step();
    endtask

    task automatic do_ack(input string tag);
        data_ack = 1'b1;
        step();
        data_ack = 1'b0;
        if (m_valid) begin
            m_valid   = 1'b0;
            m_overrun = 1'b0;
        end
        chk_model(tag);
        $display("ack %s: valid=%0d overrun=%0d", tag, data_valid, overrun);
    endtask

    // Drives one 8N1 frame. ack_at/rst_at pulse data_ack/rst at that edge
    // index (-1 for none); a reset aborts the rest of the frame.
    task automatic send_frame(input string tag, input logic [7:0] b, input logic stop_bit,
                              input int ack_at, input int rst_at);
        logic [9:0] bits;
        logic       dv_prev;
        logic       ack_eff;
        logic       aborted;
        int         rise;
        int         ferr;
        int         exp_rise;
        bits    = {stop_bit, b, 1'b0};
        dv_prev = data_valid;
        rise    = -1;
        ferr    = 0;
        aborted = 1'b0;
        ack_eff = (ack_at >= 0) && m_valid;
        for (int c = 0; c < FRAME; c++) begin
            rx       = bits[c / CPB];
            data_ack = (c == ack_at);
            rst      = (c == rst_at);
            step();
            if (c == rst_at) begin
                rst      = 1'b0;
                data_ack = 1'b0;
                rx       = 1'b1;
                m_data    = 8'h00;
                m_valid   = 1'b0;
                m_overrun = 1'b0;
                chk_reset({tag, "_rst"});
                aborted = 1'b1;
                break;
            end
            if (c == 5 * CPB) begin
                chk({tag, "_busy_mid"}, 32'(busy), 32'h1);
            end
            if (data_valid && !dv_prev && rise < 0) begin
                rise = c;
            end
            if (frame_err) begin
                ferr++;
            end
            dv_prev = data_valid;
        end
        data_ack = 1'b0;
        if (aborted) begin
            $display("frame %s: byte=%02h aborted by reset", tag, b);
        end else begin
            exp_rise = -1;
            if (stop_bit) begin
                if (m_valid && !ack_eff) begin
                    m_overrun = 1'b1;
                end else begin
                    if (!m_valid) begin
                        exp_rise = DV_CYCLE;
                    end
                    m_data    = b;
                    m_valid   = 1'b1;
                    m_overrun = 1'b0;
                end
            end else if (ack_eff) begin
                m_valid   = 1'b0;
                m_overrun = 1'b0;
            end
            chk({tag, "_ferr_count"}, 32'(ferr), stop_bit ? 32'd0 : 32'd1);
            chk({tag, "_dv_rise"}, 32'(rise), 32'(exp_rise));
            chk_model(tag);
            $display("frame %s: byte=%02h stop=%0d rx_data=%02h valid=%0d overrun=%0d ferr_pulses=%0d",
                     tag, b, stop_bit, rx_data, data_valid, overrun, ferr);
        end
    endtask

    initial begin
        int         ferr_seen;
        int         busy_seen;
        logic [7:0] rb;
        logic       rstop;
        int         rack;
        rst       = 1'b1;
        rx        = 1'b1;
        data_ack  = 1'b0;
        m_data    = 8'h00;
        m_valid   = 1'b0;
        m_overrun = 1'b0;
        repeat (3) step();
        chk_reset("por");
        rst = 1'b0;
        idle(4);
        chk_reset("por_release");
        $display("reset: rx_data=%02h valid=%0d busy=%0d", rx_data, data_valid, busy);

        // Basic reception.
        send_frame("a5", 8'hA5, 1'b1, -1, -1);
        idle(3);
        chk("a5_busy_after", 32'(busy), 32'h0);
        do_ack("a5_ack");
        do_ack("ack_when_empty");

        // Short low glitch is rejected.
        ferr_seen = 0;
        busy_seen = 0;
        rx = 1'b0;
        repeat (3) begin
            step();
            if (busy) busy_seen++;
            if (frame_err) ferr_seen++;
        end
        rx = 1'b1;
        repeat (12) begin
            step();
            if (busy) busy_seen++;
            if (frame_err) ferr_seen++;
        end
        chk("glitch_busy_seen", 32'(busy_seen != 0), 32'h1);
        chk("glitch_ferr", 32'(ferr_seen), 32'd0);
        chk("glitch_busy_end", 32'(busy), 32'h0);
        chk_model("glitch");
        $display("glitch: busy_cycles=%0d ferr=%0d valid=%0d", busy_seen, ferr_seen, data_valid);

        // Framing error, then recovery.
        send_frame("3c_bad", 8'h3C, 1'b0, -1, -1);
        chk("3c_wait_busy", 32'(busy), 32'h1);
        idle(4);
        chk("3c_busy_after", 32'(busy), 32'h0);
        send_frame("81", 8'h81, 1'b1, -1, -1);
        do_ack("81_ack");

        // Overrun.
        send_frame("11", 8'h11, 1'b1, -1, -1);
        idle(2);
        send_frame("22_over", 8'h22, 1'b1, -1, -1);
        idle(2);
        do_ack("over_ack");

        // Back-to-back with ack coincident with the second commit.
        send_frame("55", 8'h55, 1'b1, -1, -1);
        send_frame("aa_coack", 8'hAA, 1'b1, DV_CYCLE, -1);
        idle(2);

        // Reset during data bit 4, then a clean frame.
        send_frame("ff_rst", 8'hFF, 1'b1, -1, 42);
        idle(3);
        chk_reset("post_rst");
        send_frame("0f", 8'h0F, 1'b1, -1, -1);
        idle(2);
        do_ack("0f_ack");

        // Random frames against the model.
        for (int i = 0; i < 24; i++) begin
            rb    = 8'($urandom);
            rstop = ($urandom_range(0, 4) != 0);
            rack  = ($urandom_range(0, 2) == 0) ? DV_CYCLE : -1;
            send_frame($sformatf("rnd%0d", i), rb, rstop, rack, -1);
            if (!rstop) begin
                idle(3);
            end else begin
                idle($urandom_range(0, 3));
            end
            if ($urandom_range(0, 2) == 0) begin
                do_ack($sformatf("rnd%0d_ack", i));
            end
        end
        idle(3);
        chk("final_busy", 32'(busy), 32'h0);
        chk_model("final");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/uart_rx_core.md
UART_RX_CORE -- requirements
Module: uart_rx_core

Interface
REQ-001 Parameter: CLKS_PER_BIT, default 87, clk cycles per UART bit (10 MHz / 115200); legal range 4..65535.
REQ-002 Port: clk  input  1  single clock; all state updates on rising edge.
REQ-003 Port: rst  input  1  reset, synchronous, active-high.
REQ-004 Port: rx  input  1  asynchronous serial line; idle high; 8N1 framing.
REQ-005 Port: data_ack  input  1  consumer pulse; consumes held byte.
REQ-006 Port: rx_data  output  8  last committed byte.
REQ-007 Port: data_valid  output  1  level; held byte unread.
REQ-008 Port: frame_err  output  1  one-cycle pulse; stop bit sampled low.
REQ-009 Port: overrun  output  1  sticky; byte lost while data_valid high.
REQ-010 Port: busy  output  1  high in every state except IDLE.

Function
REQ-011 rx SHALL pass a 2-flop synchronizer (rx_s); all logic uses rx_s only; 2-cycle input latency.
REQ-012 FSM states SHALL be IDLE, START, DATA, STOP, WAIT_HIGH; one bit-timer counter (width ceil(log2(CLKS_PER_BIT))) and a 3-bit bit index.
REQ-013 IDLE: rx_s low SHALL enter START with timer cleared; rx_s high stays in IDLE.
REQ-014 START: at timer == CLKS_PER_BIT/2 - 1 (integer division), rx_s low -> DATA, timer cleared, index 0; rx_s high -> IDLE (glitch rejected, no flags).
REQ-015 DATA: at timer == CLKS_PER_BIT - 1, rx_s SHALL shift into shift-register MSB (LSB-first on wire), timer cleared, index incremented; after the 8th sample -> STOP.
REQ-016 STOP: at timer == CLKS_PER_BIT - 1, rx_s high -> commit (REQ-017), go to IDLE; rx_s low -> frame_err for exactly that cycle, no commit, go to WAIT_HIGH.
REQ-017 Commit SHALL update rx_data and set data_valid on the following clk edge; total latency from mid-stop-bit sample of rx_s to data_valid high is 1 cycle.
REQ-018 WAIT_HIGH SHALL stay until rx_s high for one cycle, then IDLE (break/low line never restarts reception).
REQ-019 data_ack while data_valid high SHALL clear data_valid and overrun next cycle; data_ack while data_valid low SHALL be ignored.
REQ-020 Commit while data_valid high and no data_ack same cycle SHALL discard the new byte (rx_data unchanged), set overrun, keep data_valid high.
REQ-021 Commit and data_ack same cycle SHALL load the new byte, keep data_valid high, leave overrun cleared.
REQ-022 Mid-frame falling edges SHALL be ignored; only mid-bit samples matter.
REQ-023 Back-to-back frames: a start edge in the cycle right after leaving STOP SHALL be accepted.

Reset
REQ-024 rst high SHALL, at the next clk edge, force IDLE, clear timer, index, shift register, rx_data=0x00, data_valid=0, frame_err=0, overrun=0, busy=0; synchronizer flops SHALL reset to 1.
REQ-025 rst mid-frame SHALL abandon the frame with no commit and no flags; reception resumes on the next falling edge after rst low.

Verification (CLKS_PER_BIT=8)
REQ-026 Send 0xA5 8N1 -> rx_data=0xA5, data_valid=1 one cycle after stop mid-sample, frame_err never high, busy low afterwards.
REQ-027 rx low 3 cycles then high -> FSM returns to IDLE, no data_valid, no frame_err.
REQ-028 Send 0x3C with stop bit low, then line high -> one-cycle frame_err, data_valid stays 0; next frame 0x81 received correctly.
REQ-029 Send 0x11 then 0x22 without data_ack -> rx_data=0x11, overrun=1; data_ack -> data_valid=0, overrun=0.
REQ-030 Back-to-back 0x55, 0xAA with data_ack pulsed coincident with second commit -> rx_data=0xAA, data_valid=1, overrun=0.
REQ-031 rst asserted during DATA bit 4 of 0xFF -> all outputs at reset values; subsequent 0x0F received correctly.
